fetch_queue: RTL and testbench

//  Decoupling buffer between the instruction fetch stage and the decode stage.

---
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Circular FIFO between instruction fetch and decode: buffers {PC, instruction}
// pairs, back-pressures IF when full, and discards wrong-path entries on flush.
module fetch_queue #(
  parameter int WORD_LEN = 32,
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] ifPC,
  input  logic [WORD_LEN-1:0] ifInstruction,
  input  logic                idStall,
  output logic                freezeIF,
  output logic                idValid,
  output logic [WORD_LEN-1:0] idPC,
  output logic [WORD_LEN-1:0] idInstruction,
  output logic [PTR_W:0]      count,
  output logic [CNT_W-1:0]    fullCycles,
  output logic [CNT_W-1:0]    flushCount
);

  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  logic [2*WORD_LEN-1:0] mem [DEPTH];
  logic [2*WORD_LEN-1:0] head_entry;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  push;
  logic                  pop;

  // Freeze comes only from the registered occupancy, so IF never sees idStall or flush.
  assign freezeIF = (count == FULL_LEVEL);
  assign idValid  = (count != '0);
  assign push     = ~freezeIF & ~flush;
  assign pop      = idValid & ~idStall & ~flush;

  assign head_entry    = mem[head];
  assign idPC          = idValid ? head_entry[2*WORD_LEN-1:WORD_LEN] : '0;
  assign idInstruction = idValid ? head_entry[WORD_LEN-1:0] : '0;

  // Storage carries no reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {ifPC, ifInstruction};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Both performance counters stick at all-ones until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fullCycles <= '0;
      flushCount <= '0;
    end else begin
      if (freezeIF && (fullCycles != '1)) begin
        fullCycles <= fullCycles + 1'b1;
      end
      if (flush && (flushCount != '1)) begin
        flushCount <= flushCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: streaming, back-pressure, wrap,
// flush (normal and while full) and asynchronous reset.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] ifPC;
  logic [31:0] ifInstruction;
  logic        idStall;
  logic        freezeIF;
  logic        idValid;
  logic [31:0] idPC;
  logic [31:0] idInstruction;
  logic [2:0]  count;
  logic [15:0] fullCycles;
  logic [15:0] flushCount;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.WORD_LEN(32), .DEPTH(4), .PTR_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ifPC(ifPC), .ifInstruction(ifInstruction),
    .idStall(idStall), .freezeIF(freezeIF), .idValid(idValid), .idPC(idPC),
    .idInstruction(idInstruction), .count(count), .fullCycles(fullCycles),
    .flushCount(flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0013;
  endfunction

  task automatic set_pc(input logic [31:0] pc);
    ifPC = pc;
    ifInstruction = ins(pc);
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; idStall = 1'b0; set_pc(32'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; idStall = 1'b0; set_pc(32'h0);
    #3;
    checks++;
    if ({freezeIF, idValid, idPC, idInstruction, count, fullCycles, flushCount} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got fz=%b v=%b pc=%h ins=%h cnt=%0d fc=%0d fl=%0d exp all zero",
               freezeIF, idValid, idPC, idInstruction, count, fullCycles, flushCount);
    end
    tick();
    checks++;
    if ({idValid, count} !== 4'b0) begin
      failures++;
      $display("FAIL reset_held got v=%b cnt=%0d exp 0 0", idValid, count);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (idValid !== 1'b1 || idPC !== 32'(i*4) || idInstruction !== ins(32'(i*4))) begin
        failures++;
        $display("FAIL stream_head[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                 i, idValid, idPC, idInstruction, 32'(i*4), ins(32'(i*4)));
      end
      checks++;
      if (count !== 3'd1 || freezeIF !== 1'b0) begin
        failures++;
        $display("FAIL stream_count[%0d] got cnt=%0d fz=%b exp cnt=1 fz=0", i, count, freezeIF);
      end
      set_pc(32'((i+1)*4));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    idStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 3'(i+1) || idPC !== 32'h0 || freezeIF !== (i == 3)) begin
        failures++;
        $display("FAIL fill[%0d] got cnt=%0d pc=%h fz=%b exp cnt=%0d pc=0 fz=%b",
                 i, count, idPC, freezeIF, i+1, (i == 3));
      end
      set_pc(32'((i+1)*4));
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (fullCycles !== 16'(k) || count !== 3'd4 || idPC !== 32'h0) begin
        failures++;
        $display("FAIL frozen[%0d] got fc=%0d cnt=%0d pc=%h exp fc=%0d cnt=4 pc=0",
                 k, fullCycles, count, idPC, k);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] heads [4];
    heads = '{32'd8, 32'd12, 32'd16, 32'd20};
    idStall = 1'b0;
    tick();
    checks++;
    if (count !== 3'd3 || freezeIF !== 1'b0 || idPC !== 32'd4 || fullCycles !== 16'd4) begin
      failures++;
      $display("FAIL full_pop got cnt=%0d fz=%b pc=%h fc=%0d exp cnt=3 fz=0 pc=4 fc=4",
               count, freezeIF, idPC, fullCycles);
    end
    idStall = 1'b1;
    tick();
    checks++;
    if (count !== 3'd4 || freezeIF !== 1'b1 || fullCycles !== 16'd4) begin
      failures++;
      $display("FAIL refill got cnt=%0d fz=%b fc=%0d exp cnt=4 fz=1 fc=4", count, freezeIF, fullCycles);
    end
    set_pc(32'd20);
    idStall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (idPC !== heads[k] || idInstruction !== ins(heads[k]) || count !== 3'd3) begin
        failures++;
        $display("FAIL wrap_order[%0d] got pc=%h ins=%h cnt=%0d exp pc=%h ins=%h cnt=3",
                 k, idPC, idInstruction, count, heads[k], ins(heads[k]));
      end
      if (k >= 1) set_pc(ifPC + 32'd4);
    end
  endtask

  task automatic test_flush();
    idStall = 1'b0;
    set_pc(32'h40);
    flush = 1'b1;
    tick();
    checks++;
    if (count !== 3'd0 || idValid !== 1'b0 || idInstruction !== 32'h0 || idPC !== 32'h0) begin
      failures++;
      $display("FAIL flush_empty got cnt=%0d v=%b pc=%h ins=%h exp 0 0 0 0",
               count, idValid, idPC, idInstruction);
    end
    checks++;
    if (flushCount !== 16'd1 || freezeIF !== 1'b0) begin
      failures++;
      $display("FAIL flush_count got fl=%0d fz=%b exp fl=1 fz=0", flushCount, freezeIF);
    end
    flush = 1'b0;
    set_pc(32'h80);
    tick();
    checks++;
    if (idValid !== 1'b1 || idPC !== 32'h80 || count !== 3'd1) begin
      failures++;
      $display("FAIL flush_target got v=%b pc=%h cnt=%0d exp v=1 pc=80 cnt=1", idValid, idPC, count);
    end
    set_pc(32'h84);
    tick();
    checks++;
    if (idPC !== 32'h84 || idInstruction !== ins(32'h84)) begin
      failures++;
      $display("FAIL flush_next got pc=%h ins=%h exp pc=84 ins=%h", idPC, idInstruction, ins(32'h84));
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    idStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      set_pc(32'((i+1)*4));
    end
    checks++;
    if (freezeIF !== 1'b1 || count !== 3'd4) begin
      failures++;
      $display("FAIL ff_full got fz=%b cnt=%0d exp fz=1 cnt=4", freezeIF, count);
    end
    flush = 1'b1;
    tick();
    checks++;
    if (count !== 3'd0 || freezeIF !== 1'b0 || flushCount !== 16'd1 || fullCycles !== 16'd1) begin
      failures++;
      $display("FAIL ff_flush got cnt=%0d fz=%b fl=%0d fc=%0d exp cnt=0 fz=0 fl=1 fc=1",
               count, freezeIF, flushCount, fullCycles);
    end
    flush = 1'b0;
    idStall = 1'b0;
    set_pc(32'h200);
    tick();
    checks++;
    if (idValid !== 1'b1 || idPC !== 32'h200 || count !== 3'd1) begin
      failures++;
      $display("FAIL ff_target got v=%b pc=%h cnt=%0d exp v=1 pc=200 cnt=1", idValid, idPC, count);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({freezeIF, idValid, idPC, idInstruction, count, fullCycles, flushCount} !== '0) begin
      failures++;
      $display("FAIL async_reset got fz=%b v=%b pc=%h ins=%h cnt=%0d fc=%0d fl=%0d exp all zero",
               freezeIF, idValid, idPC, idInstruction, count, fullCycles, flushCount);
    end
    tick();
    rst = 1'b0;
    set_pc(32'h300);
    tick();
    checks++;
    if (idValid !== 1'b1 || idPC !== 32'h300 || count !== 3'd1) begin
      failures++;
      $display("FAIL resume got v=%b pc=%h cnt=%0d exp v=1 pc=300 cnt=1", idValid, idPC, count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_flush();
    test_flush_full();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
